// File: rtl/btn_pkg.sv
// Shared encodings and default timing for the button event arbiter.
package btn_pkg;

  typedef enum logic {
    EVT_SHORT = 1'b0,
    EVT_LONG  = 1'b1
  } evt_type_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  localparam int DEF_TICK_DIV   = 100_000;
  localparam int DEF_LONG_TICKS = 1000;

endpackage

// File: rtl/btn_hold_timer.sv
// Per-button hold counter; raises long_set for exactly the cycle the
// count crosses from LONG_TICKS-1 to LONG_TICKS.
module btn_hold_timer
  import btn_pkg::*;
#(
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic level,
  output logic long_set
);

  localparam int CW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] LT_MAX = CW'(LONG_TICKS);
  localparam logic [CW-1:0] LT_M1  = CW'(LONG_TICKS - 1);

  logic [CW-1:0] hold_cnt;

  // Saturation at LONG_TICKS is what keeps the long request from repeating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (!level) begin
      hold_cnt <= '0;
    end else if (tick && (hold_cnt != LT_MAX)) begin
      hold_cnt <= hold_cnt + CW'(1);
    end
  end

  assign long_set = level && tick && (hold_cnt == LT_M1);

endmodule

// File: rtl/btn_event_arbiter.sv
// Collects short/long button requests, arbitrates round-robin and presents
// one event at a time through a valid/ready output register.
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         i_btn_pulse,
  input  logic [N_BTN-1:0]         i_btn_level,
  output logic                     o_evt_valid,
  input  logic                     i_evt_ready,
  output logic [$clog2(N_BTN)-1:0] o_evt_id,
  output logic                     o_evt_long,
  output logic                     o_drop,
  output logic [7:0]               o_drop_cnt
);

  localparam int IDW = $clog2(N_BTN);
  localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DNW = $clog2(2 * N_BTN + 1);

  function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [DNW-1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + 9'(inc);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // ---- p0: tick divider and hold timers
  logic [TDW-1:0]   tick_cnt;
  logic             tick;
  logic [N_BTN-1:0] long_set;

  assign tick = (tick_cnt == TDW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TDW'(1);
    end
  end

  for (genvar k = 0; k < N_BTN; k++) begin : g_hold
    btn_hold_timer #(
      .LONG_TICKS(LONG_TICKS)
    ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .level   (i_btn_level[k]),
      .long_set(long_set[k])
    );
  end

  // ---- p0: pending bits and round-robin grant
  logic [N_BTN-1:0] pend_short, pend_long;
  logic [N_BTN-1:0] req_short, req_long, req_any;
  logic [IDW-1:0]   last_id;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_id;
  evt_type_t        gnt_type;
  logic             load;
  logic [N_BTN-1:0] gnt_oh, gnt_s, gnt_l;
  logic [N_BTN-1:0] drop_s, drop_l;
  logic [DNW-1:0]   drop_num;
  out_state_t       state_q, state_d;

  // A set arriving this cycle is eligible for grant together with the
  // already-pending bits, so an idle output answers a press on the next cycle.
  assign req_short = pend_short | i_btn_pulse;
  assign req_long  = pend_long | long_set;
  assign req_any   = req_short | req_long;

  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int i = 0; i < N_BTN; i++) begin
      idx = (int'(last_id) + 1 + i) % N_BTN;
      if (!gnt_found && req_any[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  assign gnt_type = req_short[gnt_id] ? EVT_SHORT : EVT_LONG;
  assign load     = gnt_found && ((state_q == ST_EMPTY) || i_evt_ready);
  assign gnt_oh   = load ? (N_BTN'(1) << gnt_id) : '0;
  assign gnt_s    = (gnt_type == EVT_SHORT) ? gnt_oh : '0;
  assign gnt_l    = (gnt_type == EVT_LONG)  ? gnt_oh : '0;

  // A set only drops when the bit was already pending and is not being granted.
  assign drop_s = i_btn_pulse & pend_short & ~gnt_s;
  assign drop_l = long_set    & pend_long  & ~gnt_l;

  always_comb begin
    drop_num = '0;
    for (int k = 0; k < N_BTN; k++) begin
      drop_num = drop_num + DNW'(drop_s[k]) + DNW'(drop_l[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_short <= '0;
      pend_long  <= '0;
    end else begin
      pend_short <= (gnt_s & pend_short & i_btn_pulse) | (~gnt_s & (pend_short | i_btn_pulse));
      pend_long  <= (gnt_l & pend_long & long_set)     | (~gnt_l & (pend_long | long_set));
    end
  end

  // ---- p1: output stage FSM and event register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (i_evt_ready && !load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  logic [IDW-1:0] evt_id_p1;
  evt_type_t      evt_type_p1;
  logic           drop_p1;
  logic [7:0]     drop_cnt_p1;

  // Pointer resets to the top index so the first search starts at button 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_id_p1   <= '0;
      evt_type_p1 <= EVT_SHORT;
      last_id     <= IDW'(N_BTN - 1);
    end else if (load) begin
      evt_id_p1   <= gnt_id;
      evt_type_p1 <= gnt_type;
      last_id     <= gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_p1     <= 1'b0;
      drop_cnt_p1 <= '0;
    end else begin
      drop_p1     <= (drop_num != '0);
      drop_cnt_p1 <= sat_add8(drop_cnt_p1, drop_num);
    end
  end

  assign o_evt_valid = (state_q == ST_FULL);
  assign o_evt_id    = evt_id_p1;
  assign o_evt_long  = (evt_type_p1 == EVT_LONG);
  assign o_drop      = drop_p1;
  assign o_drop_cnt  = drop_cnt_p1;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with TICK_DIV=4, LONG_TICKS=3; a
// scoreboard queue holds the expected event stream.
module tb_btn_event_arbiter;

  localparam int N_BTN      = 4;
  localparam int TICK_DIV   = 4;
  localparam int LONG_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_btn_pulse;
  logic [3:0] i_btn_level;
  logic       i_evt_ready;
  logic       o_evt_valid;
  logic [1:0] o_evt_id;
  logic       o_evt_long;
  logic       o_drop;
  logic [7:0] o_drop_cnt;

  btn_event_arbiter #(
    .N_BTN     (N_BTN),
    .TICK_DIV  (TICK_DIV),
    .LONG_TICKS(LONG_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn_pulse(i_btn_pulse),
    .i_btn_level(i_btn_level),
    .o_evt_valid(o_evt_valid),
    .i_evt_ready(i_evt_ready),
    .o_evt_id   (o_evt_id),
    .o_evt_long (o_evt_long),
    .o_drop     (o_drop),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic       lng;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   evt_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle pulse starting now (just after a rising edge).
  task automatic pulse(input logic [3:0] p);
    i_btn_pulse = p;
    cyc();
    i_btn_pulse = 4'b0000;
  endtask

  task automatic push(input logic [1:0] id, input logic lng);
    exp_t e;
    e.id  = id;
    e.lng = lng;
    exp_q.push_back(e);
  endtask

  // Every accepted event is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && o_evt_valid && i_evt_ready) begin
      evt_cnt++;
      if (exp_q.size() == 0) begin
        chk("evt_unexpected", 32'(o_evt_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_id", 32'(o_evt_id), 32'(mon_e.id));
        chk("evt_long", 32'(o_evt_long), 32'(mon_e.lng));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    i_btn_pulse = 4'b0000;
    i_btn_level = 4'b0000;
    i_evt_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_valid", 32'(o_evt_valid), 32'd0);
    chk("rst_id", 32'(o_evt_id), 32'd0);
    chk("rst_long", 32'(o_evt_long), 32'd0);
    chk("rst_drop", 32'(o_drop), 32'd0);
    chk("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Simultaneous presses on 0,1,3 drain in index order
    push(2'd0, 1'b0); push(2'd1, 1'b0); push(2'd3, 1'b0);
    pulse(4'b1011);
    @(negedge clk); chk("sim_valid0", 32'(o_evt_valid), 32'd1); chk("sim_id0", 32'(o_evt_id), 32'd0);
    cyc(); @(negedge clk); chk("sim_id1", 32'(o_evt_id), 32'd1);
    cyc(); @(negedge clk); chk("sim_id3", 32'(o_evt_id), 32'd3);
    cyc(); @(negedge clk); chk("sim_idle", 32'(o_evt_valid), 32'd0);

    // Search resumes after 3: 0 before 2
    cyc();
    push(2'd0, 1'b0); push(2'd2, 1'b0);
    pulse(4'b0101);
    @(negedge clk); chk("rr_resume_id0", 32'(o_evt_id), 32'd0);
    cyc(); @(negedge clk); chk("rr_resume_id2", 32'(o_evt_id), 32'd2);
    // Last grant was 2, so 3 wins over 0
    cyc();
    push(2'd3, 1'b0); push(2'd0, 1'b0);
    pulse(4'b1001);
    @(negedge clk); chk("rr_wrap_id3", 32'(o_evt_id), 32'd3);
    cyc(); @(negedge clk); chk("rr_wrap_id0", 32'(o_evt_id), 32'd0);
    cyc(); @(negedge clk); chk("rr_wrap_idle", 32'(o_evt_valid), 32'd0);

    // Single short press on button 2
    cyc();
    push(2'd2, 1'b0);
    pulse(4'b0100);
    @(negedge clk);
    chk("single_valid", 32'(o_evt_valid), 32'd1);
    chk("single_id", 32'(o_evt_id), 32'd2);
    chk("single_long", 32'(o_evt_long), 32'd0);
    cyc(); @(negedge clk); chk("single_one_cycle", 32'(o_evt_valid), 32'd0);

    // Set and grant of the same pending bit in one cycle: no drop
    cyc();
    i_evt_ready = 1'b0;
    push(2'd0, 1'b0); push(2'd0, 1'b0); push(2'd0, 1'b0);
    pulse(4'b0001);
    pulse(4'b0001);
    i_evt_ready = 1'b1;
    pulse(4'b0001);
    @(negedge clk);
    chk("setgnt_drop", 32'(o_drop), 32'd0);
    chk("setgnt_valid", 32'(o_evt_valid), 32'd1);
    repeat (3) cyc();
    @(negedge clk);
    chk("setgnt_idle", 32'(o_evt_valid), 32'd0);
    chk("setgnt_drop_cnt", 32'(o_drop_cnt), 32'd0);
    chk("setgnt_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on button 1 with a re-press pending and a dropped third press
    cyc();
    i_evt_ready = 1'b0;
    push(2'd1, 1'b0);
    pulse(4'b0010);
    @(negedge clk);
    chk("bp_valid", 32'(o_evt_valid), 32'd1);
    chk("bp_id", 32'(o_evt_id), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      i_btn_pulse = (i == 3 || i == 6) ? 4'b0010 : 4'b0000;
      if (i == 3) push(2'd1, 1'b0);
      @(negedge clk);
      chk("bp_stall_valid", 32'(o_evt_valid), 32'd1);
      chk("bp_stall_id", 32'(o_evt_id), 32'd1);
      if (i == 4) chk("bp_no_drop", 32'(o_drop), 32'd0);
      if (i == 7) begin
        chk("bp_drop", 32'(o_drop), 32'd1);
        chk("bp_drop_cnt", 32'(o_drop_cnt), 32'd1);
      end
      if (i == 8) chk("bp_drop_one_cycle", 32'(o_drop), 32'd0);
    end
    cyc();
    i_btn_pulse = 4'b0000;
    i_evt_ready = 1'b1;
    @(negedge clk); chk("bp_rel_id_a", 32'(o_evt_id), 32'd1);
    cyc(); @(negedge clk); chk("bp_rel_valid_b", 32'(o_evt_valid), 32'd1);
    cyc(); @(negedge clk); chk("bp_rel_idle", 32'(o_evt_valid), 32'd0);

    // Long press: short then exactly one long; re-hold gives another long
    cyc();
    push(2'd0, 1'b0); push(2'd0, 1'b1);
    i_btn_level = 4'b0001;
    pulse(4'b0001);
    repeat (11) cyc();
    i_btn_level = 4'b0000;
    repeat (6) cyc();
    @(negedge clk);
    chk("long_q_empty", 32'(exp_q.size()), 32'd0);
    cyc();
    push(2'd0, 1'b1);
    i_btn_level = 4'b0001;
    repeat (12) cyc();
    i_btn_level = 4'b0000;
    repeat (6) cyc();
    @(negedge clk);
    chk("long2_q_empty", 32'(exp_q.size()), 32'd0);
    chk("long_drop_cnt", 32'(o_drop_cnt), 32'd1);

    // Drop storm: multi-drop cycles and saturation at 255
    cyc();
    i_evt_ready = 1'b0;
    pulse(4'b1111);
    pulse(4'b1111);
    @(negedge clk);
    chk("storm_drop3", 32'(o_drop), 32'd1);
    chk("storm_cnt4", 32'(o_drop_cnt), 32'd4);
    cyc();
    i_btn_pulse = 4'b1111;
    cyc();
    @(negedge clk);
    chk("storm_cnt8", 32'(o_drop_cnt), 32'd8);
    repeat (75) cyc();
    i_btn_pulse = 4'b0000;
    @(negedge clk);
    chk("storm_sat", 32'(o_drop_cnt), 32'd255);
    cyc(); @(negedge clk);
    chk("storm_sat_hold", 32'(o_drop_cnt), 32'd255);
    chk("storm_drop_end", 32'(o_drop), 32'd0);
    chk("storm_valid", 32'(o_evt_valid), 32'd1);
    chk("storm_id", 32'(o_evt_id), 32'd1);

    // Reset while an event is held
    cyc();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_evt_valid), 32'd0);
    chk("mid_rst_id", 32'(o_evt_id), 32'd0);
    chk("mid_rst_long", 32'(o_evt_long), 32'd0);
    chk("mid_rst_drop", 32'(o_drop), 32'd0);
    chk("mid_rst_cnt", 32'(o_drop_cnt), 32'd0);
    cyc();
    rst = 1'b0;
    i_evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_evt", 32'(o_evt_valid), 32'd0);
      cyc();
    end

    // Pointer back at the start: 1 before 2
    push(2'd1, 1'b0); push(2'd2, 1'b0);
    pulse(4'b0110);
    @(negedge clk); chk("post_rst_id1", 32'(o_evt_id), 32'd1);
    cyc(); @(negedge clk); chk("post_rst_id2", 32'(o_evt_id), 32'd2);
    cyc(); @(negedge clk);
    chk("final_idle", 32'(o_evt_valid), 32'd0);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
